// File: rtl/axicb_slv_switch_rd_gen.sv
// Read-path slave switch: AR decode/route, in-order R return, local DECERR.
// Optional AXICB_DECERR_CNT_EN adds a saturating DECERR request counter.
module axicb_slv_switch_rd_gen #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W = 8,
  parameter int SLV_NB = 8,
  parameter int OSTDREQ_NUM = 4,
  parameter logic [SLV_NB-1:0] MST_ROUTES = {SLV_NB{1'b1}},
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR = '0,
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR = '1,
  parameter int ARCH_W = AXI_ADDR_W+AXI_ID_W+8,
  parameter int RCH_W = AXI_ID_W+2+32
)(
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  input  logic [ARCH_W-1:0]       i_arch,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  output logic                    i_rlast,
  output logic [RCH_W-1:0]        i_rch,
  output logic [SLV_NB-1:0]       o_arvalid,
  input  logic [SLV_NB-1:0]       o_arready,
  output logic [ARCH_W-1:0]       o_arch,
  input  logic [SLV_NB-1:0]       o_rvalid,
  output logic [SLV_NB-1:0]       o_rready,
  input  logic [SLV_NB-1:0]       o_rlast,
  input  logic [SLV_NB*RCH_W-1:0] o_rch
`ifdef AXICB_DECERR_CNT_EN
  ,
  output logic [15:0]             o_decerr_cnt
`endif
);

  localparam int SEL_W = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
  localparam int PTR_W = $clog2(OSTDREQ_NUM) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [AXI_ADDR_W-1:0] ar_addr;
  logic [AXI_ID_W-1:0]   ar_id;
  logic [7:0]            ar_len;
  logic [SEL_W-1:0]      sel;
  logic                  decerr;
  logic                  slv_rdy;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [SEL_W-1:0]    fifo_sel [OSTDREQ_NUM];
  logic                fifo_dec [OSTDREQ_NUM];
  logic [AXI_ID_W-1:0] fifo_id  [OSTDREQ_NUM];
  logic [7:0]          fifo_len [OSTDREQ_NUM];

  logic [SEL_W-1:0]    h_sel;
  logic                h_dec;
  logic [AXI_ID_W-1:0] h_id;
  logic [7:0]          h_len;
  logic [7:0]          beat;

  assign ar_addr = i_arch[AXI_ADDR_W-1:0];
  assign ar_id   = i_arch[AXI_ADDR_W +: AXI_ID_W];
  assign ar_len  = i_arch[AXI_ADDR_W+AXI_ID_W +: 8];
  assign o_arch  = i_arch;

  // Descending scan so the lowest matching slave wins.
  always_comb begin
    sel    = '0;
    decerr = 1'b1;
    for (int k = SLV_NB-1; k >= 0; k--) begin
      if (MST_ROUTES[k] &&
          ar_addr >= SLV_START_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W] &&
          ar_addr <= SLV_END_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W]) begin
        sel    = SEL_W'(k);
        decerr = 1'b0;
      end
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PTR_W'(OSTDREQ_NUM));
  assign empty = (wr_ptr == rd_ptr);

  always_comb begin
    slv_rdy   = 1'b0;
    o_arvalid = '0;
    for (int k = 0; k < SLV_NB; k++) begin
      if (sel == SEL_W'(k)) begin
        slv_rdy      = o_arready[k];
        o_arvalid[k] = !srst && i_arvalid && !full && !decerr;
      end
    end
  end

  assign i_arready = !srst && !full && (decerr || slv_rdy);
  assign push = i_arvalid && i_arready;
  assign pop  = i_rvalid && i_rready && i_rlast;

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_sel[wr_ptr[IDX_W-1:0]] <= sel;
      fifo_dec[wr_ptr[IDX_W-1:0]] <= decerr;
      fifo_id[wr_ptr[IDX_W-1:0]]  <= ar_id;
      fifo_len[wr_ptr[IDX_W-1:0]] <= ar_len;
    end
  end

  assign h_sel = fifo_sel[rd_ptr[IDX_W-1:0]];
  assign h_dec = fifo_dec[rd_ptr[IDX_W-1:0]];
  assign h_id  = fifo_id[rd_ptr[IDX_W-1:0]];
  assign h_len = fifo_len[rd_ptr[IDX_W-1:0]];

  always_comb begin
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rch    = '0;
    o_rready = '0;
    if (!srst && !empty) begin
      if (h_dec) begin
        i_rvalid = 1'b1;
        i_rlast  = (beat == h_len);
        i_rch[AXI_ID_W +: 2]    = 2'b11;
        i_rch[AXI_ID_W-1:0]     = h_id;
      end else begin
        for (int k = 0; k < SLV_NB; k++) begin
          if (h_sel == SEL_W'(k)) begin
            i_rvalid    = o_rvalid[k];
            i_rlast     = o_rlast[k];
            i_rch       = o_rch[k*RCH_W +: RCH_W];
            o_rready[k] = i_rready;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      beat <= '0;
    end else if (!empty && h_dec && i_rready) begin
      beat <= i_rlast ? 8'd0 : beat + 8'd1;
    end
  end

`ifdef AXICB_DECERR_CNT_EN
  always_ff @(posedge aclk) begin
    if (srst) begin
      o_decerr_cnt <= '0;
    end else if (push && decerr && o_decerr_cnt != 16'hFFFF) begin
      o_decerr_cnt <= o_decerr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axicb_slv_switch_rd_gen.sv
// Randomized bench for axicb_slv_switch_rd_gen against a queue-based model.
// Slaves answer out of order; master/slaves hold payloads while stalled.
module tb_axicb_slv_switch_rd_gen;

  localparam int AW = 32;
  localparam int IW = 8;
  localparam int NS = 4;
  localparam int DEPTH = 4;
  localparam int ARW = AW+IW+8;
  localparam int RW = IW+2+32;
  localparam logic [NS-1:0] ROUTES = 4'b1101;
  localparam logic [NS*AW-1:0] START =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] ENDA =
    {32'h0000_3FFF, 32'h0000_37FF, 32'h0000_1FFF, 32'h0000_0FFF};

  logic aclk = 0;
  logic srst;
  logic i_arvalid, i_arready;
  logic [ARW-1:0] i_arch;
  logic i_rvalid, i_rready, i_rlast;
  logic [RW-1:0] i_rch;
  logic [NS-1:0] o_arvalid, o_arready;
  logic [ARW-1:0] o_arch;
  logic [NS-1:0] o_rvalid, o_rready, o_rlast;
  logic [NS*RW-1:0] o_rch;
`ifdef AXICB_DECERR_CNT_EN
  logic [15:0] o_decerr_cnt;
  int cnt_m;
`endif

  axicb_slv_switch_rd_gen #(
    .AXI_ADDR_W(AW), .AXI_ID_W(IW), .SLV_NB(NS),
    .OSTDREQ_NUM(DEPTH), .MST_ROUTES(ROUTES),
    .SLV_START_ADDR(START), .SLV_END_ADDR(ENDA)
  ) dut (
    .aclk(aclk), .srst(srst),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast),
    .i_rch(i_rch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast),
    .o_rch(o_rch)
`ifdef AXICB_DECERR_CNT_EN
    , .o_decerr_cnt(o_decerr_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int sel;
    bit dec;
    int id;
    int len;
    int beat;
  } route_t;

  route_t rq[$];
  logic [31:0] ws [NS] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  logic [31:0] we [NS] = '{32'h0FFF, 32'h1FFF, 32'h37FF, 32'h3FFF};
  logic [RW-1:0] spay [NS];
  bit shold [NS];
  bit ar_hold;
  int n_chk, n_err;
  int cyc;
  bit rst_now, did_rst;
  int dec_beats, full_stalls, ooo_stalls;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output int s,
                                 output bit d);
    d = 1;
    s = 0;
    for (int k = 0; k < NS; k++) begin
      if (d && ROUTES[k] && a >= ws[k] && a <= we[k]) begin
        s = k;
        d = 0;
      end
    end
  endfunction

  function automatic int find_slv(input int k);
    for (int i = 0; i < rq.size(); i++)
      if (!rq[i].dec && rq[i].sel == k) return i;
    return -1;
  endfunction

  function automatic logic [31:0] gen_addr();
    case ($urandom_range(0, 5))
      0: return 32'h0000 + 32'($urandom_range(0, 32'hFFF));
      1: return 32'h1000 + 32'($urandom_range(0, 32'hFFF));
      2: return 32'h2000 + 32'($urandom_range(0, 32'hFFF));
      3: return 32'h3000 + 32'($urandom_range(0, 32'hFFF));
      4: return 32'hF000 + 32'($urandom_range(0, 32'hFFF));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive();
    int idx;
    int rprob;
    srst = (cyc < 3) || rst_now;
    rprob = ((cyc % 200) < 50) ? 10 : 75;
    if (!ar_hold) begin
      i_arvalid = ($urandom_range(0, 99) < 70);
      i_arch = {8'($urandom_range(0, 3)), 8'($urandom), gen_addr()};
    end
    i_rready = ($urandom_range(0, 99) < rprob);
    for (int k = 0; k < NS; k++) begin
      o_arready[k] = ($urandom_range(0, 99) < 70);
      idx = find_slv(k);
      if (idx >= 0) begin
        if (!shold[k]) begin
          o_rvalid[k] = ($urandom_range(0, 99) < 60);
          spay[k] = {32'($urandom), 2'($urandom_range(0, 2)),
                     8'(rq[idx].id)};
        end
        o_rlast[k] = (rq[idx].beat == rq[idx].len);
      end else begin
        o_rvalid[k] = 1'b0;
        o_rlast[k] = 1'($urandom);
        spay[k] = {32'($urandom), 10'($urandom)};
      end
      o_rch[k*RW +: RW] = spay[k];
    end
  endtask

  task automatic check_cycle();
    int s;
    bit d;
    bit full;
    logic [NS-1:0] e_arv, e_ordy;
    bit e_ardy, e_rv, e_rl;
    logic [RW-1:0] e_rch;
    route_t t;
    decode(i_arch[AW-1:0], s, d);
    full = (rq.size() == DEPTH);
    e_arv = '0;
    e_ordy = '0;
    e_ardy = 0;
    e_rv = 0;
    e_rl = 0;
    e_rch = '0;
    if (!srst) begin
      e_ardy = !full && (d || o_arready[s]);
      if (i_arvalid && !full && !d) e_arv[s] = 1'b1;
      if (rq.size() > 0) begin
        if (rq[0].dec) begin
          e_rv = 1;
          e_rl = (rq[0].beat == rq[0].len);
          e_rch = {32'h0, 2'b11, 8'(rq[0].id)};
        end else begin
          e_rv = o_rvalid[rq[0].sel];
          e_rl = o_rlast[rq[0].sel];
          e_rch = spay[rq[0].sel];
          e_ordy[rq[0].sel] = i_rready;
        end
      end
    end
    check("arready", 64'(i_arready), 64'(e_ardy));
    check("o_arvalid", 64'(o_arvalid), 64'(e_arv));
    check("o_arch", 64'(o_arch), 64'(i_arch));
    check("rvalid", 64'(i_rvalid), 64'(e_rv));
    check("o_rready", 64'(o_rready), 64'(e_ordy));
    if (e_rv) begin
      check("rlast", 64'(i_rlast), 64'(e_rl));
      check("rch", 64'(i_rch), 64'(e_rch));
    end
`ifdef AXICB_DECERR_CNT_EN
    check("decerr_cnt", 64'(o_decerr_cnt), 64'(cnt_m));
`endif
    if (srst) begin
      rq.delete();
      ar_hold = 0;
      for (int k = 0; k < NS; k++) shold[k] = 0;
`ifdef AXICB_DECERR_CNT_EN
      cnt_m = 0;
`endif
      return;
    end
    if (i_arvalid && full) full_stalls++;
    for (int k = 0; k < NS; k++)
      if (o_rvalid[k] && rq.size() > 0 && rq[0].sel != k) ooo_stalls++;
    for (int k = 0; k < NS; k++) shold[k] = o_rvalid[k] && !e_ordy[k];
    if (rq.size() > 0 && e_rv && i_rready) begin
      if (rq[0].dec) dec_beats++;
      if (e_rl) begin
        void'(rq.pop_front());
      end else begin
        t = rq[0];
        t.beat++;
        rq[0] = t;
      end
    end
    if (i_arvalid && e_ardy) begin
      t.sel = s;
      t.dec = d;
      t.id = int'(i_arch[AW +: IW]);
      t.len = int'(i_arch[AW+IW +: 8]);
      t.beat = 0;
      rq.push_back(t);
      ar_hold = 0;
`ifdef AXICB_DECERR_CNT_EN
      if (d && cnt_m != 16'hFFFF) cnt_m++;
`endif
    end else begin
      ar_hold = i_arvalid;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    ar_hold = 0;
    rst_now = 0;
    did_rst = 0;
    dec_beats = 0;
    full_stalls = 0;
    ooo_stalls = 0;
`ifdef AXICB_DECERR_CNT_EN
    cnt_m = 0;
`endif
    for (int k = 0; k < NS; k++) shold[k] = 0;
    srst = 1;
    i_arvalid = 0;
    i_arch = '0;
    i_rready = 0;
    o_arready = '0;
    o_rvalid = '0;
    o_rlast = '0;
    o_rch = '0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge aclk);
      #1;
      rst_now = 0;
      if (cyc >= 1000 && !did_rst && rq.size() >= 3) begin
        rst_now = 1;
        did_rst = 1;
      end
      drive();
      @(negedge aclk);
      check_cycle();
    end
    check("mid_reset_hit", 64'(did_rst), 64'd1);
    check("decerr_beats_seen", 64'(dec_beats > 20), 64'd1);
    check("full_stall_seen", 64'(full_stalls > 0), 64'd1);
    check("ooo_stall_seen", 64'(ooo_stalls > 0), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
